// File: rtl/prom_prog_seq.sv
// rtl/prom_prog_seq.sv - sequences one PROM page program or sector erase through the SPI engine
// (write enable, program/erase, then RDSR polling until WIP clears or the poll budget runs out).
module prom_prog_seq #(
   parameter int POLL_GAP  = 256,
   parameter int MAX_POLLS = 65535
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        op,
   input  logic [23:0] addr,
   input  logic [6:0]  nquads,
   output logic [5:0]  buf_raddr,
   input  logic [31:0] buf_rdata,
   output logic [31:0] eng_cmd,
   output logic        eng_cmd_wen,
   output logic        eng_blk_start,
   output logic        eng_blk_wen,
   output logic [5:0]  eng_blk_waddr,
   output logic        eng_blk_end,
   input  logic        eng_busy,
   input  logic [31:0] eng_result,
   output logic        busy,
   output logic        done,
   output logic [1:0]  error
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_WREN,
      S_ERASE,
      S_PSTART,
      S_PDATA,
      S_PEND,
      S_POLL,
      S_RDSR
   } state_t;

   localparam logic [7:0]  CMD_WREN  = 8'h06;
   localparam logic [7:0]  CMD_SE    = 8'hD8;
   localparam logic [7:0]  CMD_PP    = 8'h02;
   localparam logic [7:0]  CMD_RDSR  = 8'h05;
   localparam logic [1:0]  ERR_NONE  = 2'd0;
   localparam logic [1:0]  ERR_NQ    = 2'd1;
   localparam logic [1:0]  ERR_TMO   = 2'd2;
   localparam int          GAP_LAST_I  = (POLL_GAP > 0) ? POLL_GAP - 1 : 0;
   localparam int          POLL_LIM_I  = (MAX_POLLS > 65535) ? 65535 : MAX_POLLS;
   localparam logic [15:0] GAP_LAST    = GAP_LAST_I[15:0];
   localparam logic [15:0] POLL_LIMIT  = POLL_LIM_I[15:0];

   state_t      state;
   logic        op_q;
   logic [23:0] addr_q;
   logic [6:0]  nquads_q;
   logic [1:0]  guard;
   logic [15:0] gap_cnt;
   logic [15:0] poll_cnt;
   logic [6:0]  quad_idx;
   logic [31:0] cmd_q;
   logic        data_phase;

   logic        wait_done;
   logic [15:0] poll_next;
   logic [6:0]  quad_next;
   logic        nquads_bad;
   logic        result_unused;

   // Buffer data has one cycle of read latency, so data quadlets bypass the command register.
   assign eng_cmd       = data_phase ? buf_rdata : cmd_q;
   assign wait_done     = (guard == 2'd0) && !eng_busy;
   assign poll_next     = (poll_cnt == 16'hFFFF) ? poll_cnt : poll_cnt + 16'd1;
   assign quad_next     = quad_idx + 7'd1;
   assign nquads_bad    = (nquads == 7'd0) || (nquads > 7'd64);
   assign result_unused = ^eng_result[31:1];

   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= S_IDLE;
         op_q          <= 1'b0;
         addr_q        <= 24'h0;
         nquads_q      <= 7'd0;
         guard         <= 2'd0;
         gap_cnt       <= 16'd0;
         poll_cnt      <= 16'd0;
         quad_idx      <= 7'd0;
         cmd_q         <= 32'h0;
         data_phase    <= 1'b0;
         buf_raddr     <= 6'd0;
         eng_cmd_wen   <= 1'b0;
         eng_blk_start <= 1'b0;
         eng_blk_wen   <= 1'b0;
         eng_blk_waddr <= 6'd0;
         eng_blk_end   <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         error         <= ERR_NONE;
      end else begin
         eng_cmd_wen   <= 1'b0;
         eng_blk_start <= 1'b0;
         eng_blk_end   <= 1'b0;
         done          <= 1'b0;
         if (guard != 2'd0)
            guard <= guard - 2'd1;

         case (state)
            S_IDLE: begin
               if (start) begin
                  op_q     <= op;
                  addr_q   <= addr;
                  nquads_q <= nquads;
                  error    <= ERR_NONE;
                  if (!op && nquads_bad) begin
                     error <= ERR_NQ;
                     done  <= 1'b1;
                  end else begin
                     busy        <= 1'b1;
                     poll_cnt    <= 16'd0;
                     cmd_q       <= {CMD_WREN, 24'h0};
                     eng_cmd_wen <= 1'b1;
                     guard       <= 2'd2;
                     state       <= S_WREN;
                  end
               end
            end

            S_WREN: begin
               if (wait_done) begin
                  if (op_q) begin
                     cmd_q       <= {CMD_SE, addr_q};
                     eng_cmd_wen <= 1'b1;
                     guard       <= 2'd2;
                     state       <= S_ERASE;
                  end else begin
                     eng_blk_start <= 1'b1;
                     state         <= S_PSTART;
                  end
               end
            end

            S_ERASE: begin
               if (wait_done) begin
                  gap_cnt <= 16'd0;
                  state   <= S_POLL;
               end
            end

            S_PSTART: begin
               cmd_q         <= {CMD_PP, addr_q};
               eng_blk_wen   <= 1'b1;
               eng_blk_waddr <= 6'd0;
               buf_raddr     <= 6'd0;
               quad_idx      <= 7'd0;
               state         <= S_PDATA;
            end

            // quad_idx is the waddr currently on the bus; 64 wraps to 0 in the 6-bit index.
            S_PDATA: begin
               if (quad_idx == nquads_q) begin
                  eng_blk_wen <= 1'b0;
                  data_phase  <= 1'b0;
                  eng_blk_end <= 1'b1;
                  guard       <= 2'd2;
                  state       <= S_PEND;
               end else begin
                  quad_idx      <= quad_next;
                  eng_blk_waddr <= quad_next[5:0];
                  buf_raddr     <= quad_next[5:0];
                  data_phase    <= 1'b1;
               end
            end

            S_PEND: begin
               if (wait_done) begin
                  gap_cnt <= 16'd0;
                  state   <= S_POLL;
               end
            end

            S_POLL: begin
               if (gap_cnt >= GAP_LAST) begin
                  cmd_q       <= {CMD_RDSR, 24'h0};
                  eng_cmd_wen <= 1'b1;
                  guard       <= 2'd2;
                  state       <= S_RDSR;
               end else begin
                  gap_cnt <= gap_cnt + 16'd1;
               end
            end

            S_RDSR: begin
               if (wait_done) begin
                  poll_cnt <= poll_next;
                  if (!eng_result[0]) begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     error <= ERR_NONE;
                     state <= S_IDLE;
                  end else if (poll_next >= POLL_LIMIT) begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     error <= ERR_TMO;
                     state <= S_IDLE;
                  end else begin
                     gap_cnt <= 16'd0;
                     state   <= S_POLL;
                  end
               end
            end

            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/prom_prog_seq.md
Name: prom_prog_seq

Overview:
- Sequences one complete PROM write operation: page program (up to 64 data quadlets) or sector erase.
- Drives the SPI PROM engine's command and block-write interface, one step at a time:
  - issues Write Enable (0x06);
  - issues the program block or erase command;
  - polls Read Status Register (0x05) until WIP=0.
- Sits between the host register decode and the SPI engine, replacing host-driven multi-step programming.

Parameters:
- POLL_GAP, 256, clk cycles idle between consecutive RDSR polls.
- MAX_POLLS, 65535, RDSR polls allowed before timeout error.

Ports:
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-low
- start  in  1  one-cycle request; ignored unless idle
- op  in  1  0=page program, 1=sector erase
- addr  in  24  PROM byte address
- nquads  in  7  data quadlets to program (1..64); ignored for erase
- buf_raddr  out  6  data buffer read address
- buf_rdata  in  32  data buffer read data, valid 1 cycle after buf_raddr
- eng_cmd  out  32  command/data quadlet to engine
- eng_cmd_wen  out  1  one-cycle single-command strobe
- eng_blk_start  out  1  one-cycle block-write start strobe
- eng_blk_wen  out  1  block quadlet strobe
- eng_blk_waddr  out  6  block quadlet index
- eng_blk_end  out  1  one-cycle block-write end strobe
- eng_busy  in  1  engine not idle
- eng_result  in  32  engine result; [0]=WIP after RDSR
- busy  out  1  sequence in progress
- done  out  1  one-cycle completion pulse
- error  out  2  0 none, 1 bad nquads, 2 poll timeout; held until next start

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0. Reset mid-operation returns to IDLE immediately and sends no further strobes. The engine's own state is not touched.
- Single-cycle strobes: eng_cmd_wen, eng_blk_start, eng_blk_end, done.
- Wait rule ("wait"): after any strobe, count 2 guard cycles, then wait until eng_busy=0.
- States and transitions:
  - IDLE: on start, latch op/addr/nquads and clear error.
    - If op=0 and nquads is 0 or >64: error=1, pulse done, stay IDLE.
    - Otherwise busy=1 and go to WREN.
    - busy=0 only in IDLE.
  - WREN: eng_cmd={8'h06,24'h0}, strobe eng_cmd_wen, wait.
    - Then go to ERASE if op=1, else PSTART.
  - ERASE: eng_cmd={8'hD8,addr}, strobe eng_cmd_wen, wait, go to POLL.
  - PSTART: strobe eng_blk_start.
    - Next cycle: eng_cmd={8'h02,addr}, eng_blk_wen=1, eng_blk_waddr=0, buf_raddr=0.
  - PDATA: for k=1..nquads, eng_cmd=buf_rdata from buf_raddr=k-1, eng_blk_waddr=k.
    - Pipelined: one quadlet per cycle after the 1-cycle buffer latency, eng_blk_wen high continuously.
    - Total nquads+1 quadlets; the last has waddr=nquads[5:0]. waddr 64 wraps to 0 in 6 bits, which is legal (engine tracks a 7-bit index).
  - PEND: strobe eng_blk_end on the cycle after the last quadlet, wait, go to POLL.
  - POLL: wait POLL_GAP cycles, eng_cmd={8'h05,24'h0}, strobe eng_cmd_wen, wait, increment poll count, then sample eng_result[0].
    - WIP=0: go to IDLE, pulse done, error=0.
    - WIP=1 and count=MAX_POLLS: go to IDLE, pulse done, error=2.
    - Otherwise repeat POLL.
- Latency:
  - start to WREN strobe: 1 cycle.
  - Block quadlets: no bubbles between eng_blk_start+1 and the last quadlet.
- start while busy: ignored, no effect on the sequence.
- eng_busy stuck high: the sequencer waits indefinitely (the engine guarantees completion).
- Poll counter: 16 bits, saturating.

Test Plan:
- Page program, nquads=4, addr=0x012300, buffer [A0..A3], engine model idle after 40 cycles, WIP=1 for 3 polls then 0:
  - eng_cmd_wen with 0x06000000;
  - eng_blk_start;
  - 5 consecutive eng_blk_wen with waddr 0..4, data 0x02012300,A0..A3;
  - eng_blk_end;
  - 4 RDSR cmds 0x05000000;
  - done pulse, error=0.
- Sector erase, addr=0x0A0000:
  - commands 0x06000000, 0xD80A0000, then RDSR polls;
  - no eng_blk_* strobes;
  - done, error=0.
- nquads=64: 65 block quadlets, last waddr=0; nquads=0 or 65: done within 1 cycle, error=1, no engine strobes.
- MAX_POLLS=3, WIP always 1: exactly 3 RDSR commands, then done, error=2; next valid start clears error.
- start asserted during PDATA: ignored, sequence unchanged.
- reset low mid-PDATA: next cycle all outputs 0, IDLE; a fresh start then runs a full sequence correctly.
